mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single 256-bit-line off-chip data memory port between the instruction cache (port 0) and the data cache (port 1).
- Grants one requester at a time and latches that requester's command.
- Holds mem_enable_o until mem_ack_i, then returns a one-cycle ack and the read line to the granted requester.
- Sits between the CPU's cache controllers and Data_Memory, at the top level beside CPU.

Parameters:
- LINE_W, 256, memory line width in bits.
- ADDR_W, 32, byte address width.
- TIMEOUT, 64, maximum cycles to wait for mem_ack_i before flagging an error.
- RR_EN, 1, 1 = round-robin between ports; 0 = fixed priority, port 1 (dcache) wins.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- p0_enable_i  in  1  icache request; held high until p0_ack_o.
- p0_write_i  in  1  icache write (0 = read).
- p0_addr_i  in  ADDR_W  icache line address.
- p0_data_i  in  LINE_W  icache write line.
- p0_data_o  out  LINE_W  read line to icache.
- p0_ack_o  out  1  one-cycle completion to icache.
- p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_data_o, p1_ack_o: same as port 0, for the dcache.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  memory write.
- mem_addr_o  out  ADDR_W  memory address.
- mem_data_o  out  LINE_W  memory write data.
- mem_data_i  in  LINE_W  memory read data, valid with mem_ack_i.
- mem_ack_i  in  1  memory completion pulse.
- grant_o  out  1  index of the owning port; valid while busy_o.
- busy_o  out  1  a transaction is in flight.
- timeout_o  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, last-grant pointer = 1 (so port 0 wins the first tie under RR), timeout counter 0.
- State IDLE:
  - If any pN_enable_i is high, choose the winner.
    - RR_EN=1: on a tie, the port not granted last wins.
    - RR_EN=0: port 1 always wins.
  - Register the winner's write, addr and data into mem_*_o; set mem_enable_o=1, busy_o=1, grant_o=winner; update the last-grant pointer. Go to MEM.
  - With no request, stay in IDLE with mem_enable_o=0.
- State MEM:
  - mem_* outputs stay stable; requester inputs are not re-sampled.
  - The timeout counter increments each cycle.
  - On mem_ack_i=1:
    - Capture mem_data_i into the winner's pN_data_o (reads only; on writes pN_data_o keeps its old value).
    - Drop mem_enable_o and clear the counter. Go to DONE.
  - If the counter reaches TIMEOUT-1 with no ack: set timeout_o=1 and go to DONE anyway. The data output is not updated.
- State DONE (exactly one cycle):
  - pN_ack_o=1 for the winner only; busy_o stays 1. Go to IDLE.
  - Requesters drop enable on the edge that samples ack. A request still high in the IDLE cycle after DONE is treated as a new request.
- Latency:
  - Request seen in IDLE at edge k → mem_enable_o high from cycle k+1.
  - Memory ack at cycle m → pN_ack_o high in cycle m+1.
  - Minimum occupancy is 3 cycles (IDLE, MEM, DONE).
- The non-granted requester keeps its enable asserted and waits. No starvation under RR_EN=1.
- mem_ack_i outside MEM is ignored.
- pN_data_o holds its last captured line until the next read completion for that port.
- Reset mid-transaction: all state clears at once; mem_enable_o drops asynchronously; no ack is issued.

Decomposition:
- Shared package mem_if_pkg:
  - LINE_W and ADDR_W constants.
  - State enum {IDLE, MEM, DONE}.
  - Port-index constants PORT_I=0, PORT_D=1.
- One natural sub-module: rr_arbiter2. A combinational 2-way round-robin/priority pick plus the registered last-grant pointer.

Test Plan:
- Single read: p0 read addr 0x0000_0040; memory acks after 10 cycles with 0xA5 repeated → mem_addr_o=0x40 one cycle after request; p0_ack_o high for exactly 1 cycle; p0_data_o=0xA5…A5; p1_ack_o never high.
- Simultaneous requests, RR_EN=1: both ports read from reset → port 0 is granted first and port 1 next; with both held continuously, grants alternate 0,1,0,1 over 4 transactions.
- RR_EN=0 contention: both ports request continuously for 3 transactions → port 1 granted all 3; port 0 granted only after p1_enable_i drops.
- Write then read: p1 writes 0x1234… to addr 0x80, then p0 reads 0x80 → mem_write_o=1 with mem_data_o=0x1234… during the first transaction; p1_data_o unchanged; p0_data_o = the memory-model line.
- Timeout, TIMEOUT=8: memory never acks → after 8 MEM cycles timeout_o=1 and stays 1, p0_ack_o pulses once, state returns to IDLE, and the next request is served normally.
- Reset mid-MEM: assert rst_i 3 cycles into MEM → mem_enable_o=0, busy_o=0 immediately; a late mem_ack_i after reset produces no pN_ack_o.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared constants and state encoding for the cache/memory arbitration path.
package mem_if_pkg;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {IDLE, MEM, DONE} state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way pick: round-robin on ties (RR_EN=1) or fixed priority to port 1.
module rr_arbiter2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       take,
  output logic       win,
  output logic       valid
);
  logic last_q;

  always_comb begin
    valid = |req;
    if (&req) win = RR_EN ? ~last_q : 1'b1;
    else      win = req[1];
  end

  // Starts at 1 so port 0 takes the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     last_q <= 1'b1;
    else if (take) last_q <= win;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between icache (port 0) and dcache (port 1);
// one transaction at a time: IDLE -> MEM (until ack or timeout) -> DONE.
module mem_arbiter #(
  parameter int LINE_W  = mem_if_pkg::LINE_W,
  parameter int ADDR_W  = mem_if_pkg::ADDR_W,
  parameter int TIMEOUT = 64,
  parameter bit RR_EN   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [LINE_W-1:0] p0_data_i,
  output logic [LINE_W-1:0] p0_data_o,
  output logic              p0_ack_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [LINE_W-1:0] p1_data_i,
  output logic [LINE_W-1:0] p1_data_o,
  output logic              p1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              grant_o,
  output logic              busy_o,
  output logic              timeout_o
);
  import mem_if_pkg::state_e;
  import mem_if_pkg::IDLE;
  import mem_if_pkg::MEM;
  import mem_if_pkg::DONE;
  import mem_if_pkg::PORT_I;
  import mem_if_pkg::PORT_D;

  localparam int               CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             win, req_any, take;

  assign take = (state_q == IDLE) && req_any;

  rr_arbiter2 #(.RR_EN(RR_EN)) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req   ({p1_enable_i, p0_enable_i}),
    .take  (take),
    .win   (win),
    .valid (req_any)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_any) state_d = MEM;
      MEM:     if (mem_ack_i || cnt_q == CNT_MAX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_enable_o = (state_q == MEM);
    busy_o       = (state_q != IDLE);
    p0_ack_o     = (state_q == DONE) && (grant_o == PORT_I);
    p1_ack_o     = (state_q == DONE) && (grant_o == PORT_D);
  end

  // Command is latched once at grant; requester inputs are ignored until IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_o     <= 1'b0;
      mem_write_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      cnt_q       <= '0;
      timeout_o   <= 1'b0;
      p0_data_o   <= '0;
      p1_data_o   <= '0;
    end else begin
      if (take) begin
        grant_o     <= win;
        mem_write_o <= win ? p1_write_i : p0_write_i;
        mem_addr_o  <= win ? p1_addr_i  : p0_addr_i;
        mem_data_o  <= win ? p1_data_i  : p0_data_i;
      end
      if (state_q == MEM) begin
        if (mem_ack_i) begin
          cnt_q <= '0;
          if (!mem_write_o) begin
            if (grant_o == PORT_D) p1_data_o <= mem_data_i;
            else                   p0_data_o <= mem_data_i;
          end
        end else if (cnt_q == CNT_MAX) begin
          cnt_q     <= '0;
          timeout_o <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin instance (TIMEOUT 64) and fixed-priority
// instance (TIMEOUT 8) share requester/memory inputs; a line model supplies reads.
module tb_mem_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  logic clk = 1'b0, rst = 1'b0;
  logic p0_en = 1'b0, p0_wr = 1'b0, p1_en = 1'b0, p1_wr = 1'b0, mem_ack = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [LW-1:0] p0_wdata = '0, p1_wdata = '0, mem_rdata = '0;

  logic [LW-1:0] p0_rd, p1_rd, mem_wd, p0_rd_f, p1_rd_f, mem_wd_f;
  logic [AW-1:0] mem_a, mem_a_f;
  logic p0_ack, p1_ack, mem_en, mem_wr, grant, busy, tmo;
  logic p0_ack_f, p1_ack_f, mem_en_f, mem_wr_f, grant_f, busy_f, tmo_f;

  int checks = 0, errors = 0;
  logic [LW-1:0] exp_d [2];
  logic [LW-1:0] mem_m [logic [AW-1:0]];

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(64), .RR_EN(1'b1)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .p0_enable_i(p0_en), .p0_write_i(p0_wr), .p0_addr_i(p0_addr), .p0_data_i(p0_wdata),
    .p0_data_o(p0_rd), .p0_ack_o(p0_ack),
    .p1_enable_i(p1_en), .p1_write_i(p1_wr), .p1_addr_i(p1_addr), .p1_data_i(p1_wdata),
    .p1_data_o(p1_rd), .p1_ack_o(p1_ack),
    .mem_enable_o(mem_en), .mem_write_o(mem_wr), .mem_addr_o(mem_a), .mem_data_o(mem_wd),
    .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
    .grant_o(grant), .busy_o(busy), .timeout_o(tmo)
  );

  mem_arbiter #(.TIMEOUT(8), .RR_EN(1'b0)) u_fp (
    .clk_i(clk), .rst_i(rst),
    .p0_enable_i(p0_en), .p0_write_i(p0_wr), .p0_addr_i(p0_addr), .p0_data_i(p0_wdata),
    .p0_data_o(p0_rd_f), .p0_ack_o(p0_ack_f),
    .p1_enable_i(p1_en), .p1_write_i(p1_wr), .p1_addr_i(p1_addr), .p1_data_i(p1_wdata),
    .p1_data_o(p1_rd_f), .p1_ack_o(p1_ack_f),
    .mem_enable_o(mem_en_f), .mem_write_o(mem_wr_f), .mem_addr_o(mem_a_f), .mem_data_o(mem_wd_f),
    .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
    .grant_o(grant_f), .busy_o(busy_f), .timeout_o(tmo_f)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  task automatic do_reset();
    p0_en = 1'b0; p1_en = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    exp_d[0] = '0; exp_d[1] = '0;
  endtask

  task automatic set_req(input bit p, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
    if (p) begin p1_en = 1'b1; p1_wr = wr; p1_addr = a; p1_wdata = d; end
    else   begin p0_en = 1'b1; p0_wr = wr; p0_addr = a; p0_wdata = d; end
  endtask

  // One full transaction on the round-robin instance, starting at an IDLE negedge.
  // w: expected winner; lat: extra MEM cycles before ack; wf: expected fixed-priority grant or -1.
  task automatic txn(input bit w, input int lat, input int wf, input string tag);
    bit wr;
    logic [AW-1:0] a;
    logic [LW-1:0] wd, line;
    wr = w ? p1_wr : p0_wr;
    a  = w ? p1_addr : p0_addr;
    wd = w ? p1_wdata : p0_wdata;
    line = line_of(a);
    tick();
    chkb({tag, ":mem_en"}, mem_en, 1'b1);
    chkb({tag, ":grant"}, grant, w);
    if (wf >= 0) chkb({tag, ":grant_fp"}, grant_f, wf[0]);
    chkv({tag, ":addr"}, LW'(mem_a), LW'(a));
    chkb({tag, ":write"}, mem_wr, wr);
    if (wr) chkv({tag, ":wdata"}, mem_wd, wd);
    repeat (lat) begin
      tick();
      chkb({tag, ":held"}, mem_en & ~p0_ack & ~p1_ack, 1'b1);
    end
    mem_ack = 1'b1;
    mem_rdata = wr ? {8{$urandom}} : line;
    if (wr) mem_m[a] = wd;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    chkb({tag, ":ack_win"}, w ? p1_ack : p0_ack, 1'b1);
    chkb({tag, ":ack_other"}, w ? p0_ack : p1_ack, 1'b0);
    chkb({tag, ":busy_done"}, busy, 1'b1);
    chkb({tag, ":en_drop"}, mem_en, 1'b0);
    if (w) p1_en = 1'b0; else p0_en = 1'b0;
    if (!wr) exp_d[w] = line;
    tick();
    chkb({tag, ":idle"}, busy | p0_ack | p1_ack, 1'b0);
    chkv({tag, ":p0_data"}, p0_rd, exp_d[0]);
    chkv({tag, ":p1_data"}, p1_rd, exp_d[1]);
  endtask

  initial begin
    bit last, w;
    bit [1:0] pend;
    #1;
    do_reset();
    chkb("rst:mem_en", mem_en | mem_en_f, 1'b0);
    chkb("rst:busy", busy | busy_f, 1'b0);
    chkb("rst:grant", grant | grant_f, 1'b0);
    chkb("rst:timeout", tmo | tmo_f, 1'b0);
    chkb("rst:acks", p0_ack | p1_ack | p0_ack_f | p1_ack_f, 1'b0);
    chkb("rst:mem_wr", mem_wr, 1'b0);
    chkv("rst:addr", LW'(mem_a), '0);
    chkv("rst:p0_data", p0_rd, '0);

    // Single read, slow memory (fixed-priority copy times out here and is ignored).
    mem_m[32'h40] = {32{8'hA5}};
    set_req(1'b0, 1'b0, 32'h40, '0);
    txn(1'b0, 9, -1, "rd1");
    chkv("rd1:a5", p0_rd, {32{8'hA5}});

    // Both ports held: RR alternates, fixed priority always picks port 1.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(1'b0, 1'b0, 32'h100, '0);
      set_req(1'b1, 1'b0, 32'h180, '0);
      txn(1'(i % 2), 2, 1, "contend");
    end
    p1_en = 1'b0;
    txn(1'b0, 1, 0, "p1_gone");

    // Write then read of the same line.
    set_req(1'b1, 1'b1, 32'h80, {8{32'h1234_5678}});
    txn(1'b1, 3, 1, "wr80");
    chkv("wr80:fp_wdata", mem_wd_f, {8{32'h1234_5678}});
    set_req(1'b0, 1'b0, 32'h80, '0);
    txn(1'b0, 1, 0, "rd80");
    chkv("rd80:line", p0_rd, {8{32'h1234_5678}});

    // Timeout on the TIMEOUT=8 instance, then a normal transaction.
    do_reset();
    set_req(1'b0, 1'b0, 32'h100, '0);
    tick();
    repeat (8) begin
      chkb("to:mem_en", mem_en_f, 1'b1);
      chkb("to:flag_early", tmo_f, 1'b0);
      tick();
    end
    chkb("to:ack", p0_ack_f, 1'b1);
    chkb("to:ack_other", p1_ack_f, 1'b0);
    chkb("to:flag", tmo_f, 1'b1);
    chkb("to:busy", busy_f, 1'b1);
    chkb("to:en_drop", mem_en_f, 1'b0);
    p0_en = 1'b0;
    tick();
    chkb("to:ack_once", p0_ack_f | busy_f, 1'b0);
    chkv("to:data_kept", p0_rd_f, '0);
    set_req(1'b1, 1'b0, 32'h140, '0);
    tick();
    chkb("to2:grant", grant_f, 1'b1);
    chkb("to2:mem_en", mem_en_f, 1'b1);
    chkb("to2:write", mem_wr_f, 1'b0);
    chkv("to2:addr", LW'(mem_a_f), LW'(32'h140));
    mem_ack = 1'b1; mem_rdata = line_of(32'h140);
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    chkb("to2:ack", p1_ack_f, 1'b1);
    p1_en = 1'b0;
    tick();
    chkv("to2:data", p1_rd_f, line_of(32'h140));
    chkb("to2:sticky", tmo_f, 1'b1);

    // Reset three cycles into MEM; late ack must be ignored.
    do_reset();
    set_req(1'b0, 1'b0, 32'h200, '0);
    tick(); tick(); tick();
    chkb("rm:in_mem", mem_en, 1'b1);
    rst = 1'b1;
    #1;
    chkb("rm:en_async", mem_en | mem_en_f, 1'b0);
    chkb("rm:busy_async", busy | busy_f, 1'b0);
    p0_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    mem_ack = 1'b1; mem_rdata = {8{$urandom}};
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    chkb("rm:no_ack", p0_ack | p1_ack | p0_ack_f | p1_ack_f, 1'b0);
    tick();
    chkb("rm:no_ack2", p0_ack | p1_ack | busy, 1'b0);
    chkv("rm:data", p0_rd, '0);

    // Randomized traffic on the round-robin instance against the rule-level model.
    do_reset();
    last = 1'b1;
    pend = 2'b00;
    for (int n = 0; n < 40; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          set_req(1'(p), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)) << 6, {8{$urandom}});
          pend[p] = 1'b1;
        end
      end
      if (pend == 2'b00) begin
        w = 1'($urandom_range(0, 1));
        set_req(w, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)) << 6, {8{$urandom}});
        pend[w] = 1'b1;
      end
      w = (pend == 2'b11) ? ~last : pend[1];
      last = w;
      txn(w, $urandom_range(0, 5), -1, "rand");
      pend[w] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
